// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch front end.
//   regval_t      : 32-bit architectural register / address value
//   NR            : architectural register count used by later stages
//   fetch_state_t : fetch sequencer states
//   fetch_entry_t : one prefetch queue entry (word, its pc, post-redirect flag)
package instruction_fetch_pkg;

    localparam int NR = 32;

    typedef logic [31:0] regval_t;

    typedef enum logic [1:0] {
        REQUEST   = 2'd0,
        WAIT_DATA = 2'd1,
        DISCARD   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        regval_t instruction;
        regval_t pc;
        logic    has_flushed;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of DEPTH fetch entries.
//   clock, reset_n : system clock, async active-low reset
//   flush          : empty the queue (wins over push/pop)
//   push, push_entry : write a new entry at the tail
//   pop            : drop the head entry
//   full, empty    : occupancy flags
//   head_entry     : oldest entry, valid when !empty
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head_entry
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_entry;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front stage: issues one memory read at a time, queues the
// returned words with their pc for decode, and handles pc redirects.
//   clock, reset_n        : system clock, async active-low reset
//   address_enable/address: read request strobe and byte address
//   data, data_valid      : read response (one pulse per accepted request)
//   redirect_valid/_pc    : flush and restart fetch at redirect_pc
//   next_pc               : sequential successor of the oldest queued pc
//   out_valid/_instruction/_pc/_has_flushed, hold : decode interface
// Optional macro FETCH_PERF_COUNT_EN adds saturating stall_cycles and
// flush_count outputs.
//
// state     | meaning
// REQUEST   | idle; issue a read when the queue has room
// WAIT_DATA | read in flight, response will be queued
// DISCARD   | read in flight after a redirect, response will be dropped
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int      DEPTH    = 2,
    parameter regval_t RESET_PC = 32'h0000_0000,
    parameter int      PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        address_enable,
    output regval_t     address,
    input  logic [31:0] data,
    input  logic        data_valid,
    input  logic        redirect_valid,
    input  regval_t     redirect_pc,
    output regval_t     next_pc,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output regval_t     out_pc,
    output logic        out_has_flushed,
    input  logic        hold
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam regval_t STEP = regval_t'(PC_STEP);

    fetch_state_t state_q, state_d;
    regval_t      fetch_pc_q, fetch_pc_d;
    regval_t      req_addr_q, req_addr_d;
    logic         flush_pending_q, flush_pending_d;
    // Holds off the first request until a clock after reset release.
    logic         run_q;
    logic         issue;
    logic         q_push;
    logic         q_pop;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        req_addr_d      = req_addr_q;
        flush_pending_d = flush_pending_q;
        address_enable  = 1'b0;
        issue           = 1'b0;
        q_push          = 1'b0;
        case (state_q)
            REQUEST: begin
                if (run_q && !q_full) begin
                    issue          = 1'b1;
                    address_enable = 1'b1;
                    req_addr_d     = fetch_pc_q;
                    state_d        = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                address_enable = 1'b1;
                if (data_valid) begin
                    q_push          = 1'b1;
                    fetch_pc_d      = fetch_pc_q + STEP;
                    flush_pending_d = 1'b0;
                    state_d         = REQUEST;
                end
            end
            DISCARD: begin
                address_enable = 1'b1;
                if (data_valid) begin
                    state_d = REQUEST;
                end
            end
            default: begin
                state_d = REQUEST;
            end
        endcase
        if (redirect_valid) begin
            q_push          = 1'b0;
            fetch_pc_d      = redirect_pc;
            flush_pending_d = 1'b1;
            // Any read still outstanding after this edge belongs to the old path.
            if (state_q == REQUEST) begin
                state_d = issue ? DISCARD : REQUEST;
            end else begin
                state_d = data_valid ? REQUEST : DISCARD;
            end
        end
    end

    // Address is frozen while a read is outstanding, even across a redirect.
    assign address = (state_q == REQUEST) ? fetch_pc_q : req_addr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= REQUEST;
            fetch_pc_q      <= RESET_PC;
            req_addr_q      <= RESET_PC;
            flush_pending_q <= 1'b0;
            run_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            req_addr_q      <= req_addr_d;
            flush_pending_q <= flush_pending_d;
            run_q           <= 1'b1;
        end
    end

    assign push_entry.instruction = data;
    assign push_entry.pc          = fetch_pc_q;
    assign push_entry.has_flushed = flush_pending_q;
    assign q_pop                  = out_valid && !hold;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .full       (q_full),
        .empty      (q_empty),
        .head_entry (head_entry)
    );

    assign out_valid       = !q_empty;
    assign out_instruction = head_entry.instruction;
    assign out_pc          = head_entry.pc;
    assign out_has_flushed = head_entry.has_flushed && out_valid;
    assign next_pc         = out_valid ? (head_entry.pc + STEP) : (fetch_pc_q + STEP);

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((state_q == WAIT_DATA || state_q == DISCARD) && q_empty &&
            (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (redirect_valid && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] STEP = 32'd4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_has_flushed;
    logic        hold;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clock = ~clock;

    instruction_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .address_enable  (address_enable),
        .address         (address),
        .data            (data),
        .data_valid      (data_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .next_pc         (next_pc),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_has_flushed (out_has_flushed),
        .hold            (hold)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        fl;
    } exp_t;

    // Reference model: the instructions decode should see, oldest first.
    exp_t        mq[$];
    logic [31:0] mpc;
    logic        mflush;
    // Memory model state.
    bit          busy;
    bit          stale;
    bit          resp_real;
    bit          inflight;
    int          cnt;
    int          lat;
    logic [31:0] req_addr;
    int          m_stall;
    int          m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Apply the effect of the clock edge just passed, then compare outputs.
    task automatic model_and_check();
        exp_t e;
        if (inflight && mq.size() == 0) m_stall++;
        if (redirect_valid) begin
            m_flush++;
            mq.delete();
            mpc    = redirect_pc;
            mflush = 1'b1;
            if (resp_real) stale = 1'b0;
            if (busy) stale = 1'b1;
        end else begin
            if (mq.size() != 0 && !hold) void'(mq.pop_front());
            if (resp_real) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    e.ins = data;
                    e.pc  = mpc;
                    e.fl  = mflush;
                    mq.push_back(e);
                    mpc    = mpc + STEP;
                    mflush = 1'b0;
                end
            end
        end
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instruction", out_instruction, mq[0].ins);
            check("out_has_flushed", out_has_flushed, mq[0].fl);
            check("next_pc", next_pc, mq[0].pc + STEP);
        end else begin
            check("next_pc_empty", next_pc, mpc + STEP);
            check("out_has_flushed_empty", out_has_flushed, 1'b0);
        end
        if (busy) begin
            check("addr_en_inflight", address_enable, 1'b1);
            check("address_stable", address, req_addr);
        end else begin
            check("addr_en_idle", address_enable, mq.size() < DEPTH);
            if (address_enable) check("request_address", address, mpc);
        end
`ifdef FETCH_PERF_COUNT_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", {16'h0, flush_count}, m_flush);
`endif
    endtask

    // Memory response and input drive for the coming cycle.
    // rmode: 0 none, 1 redirect, 2 redirect only with a response, 3 only with a read pending.
    task automatic mem_drive(input bit h, input int rmode, input logic [31:0] rpc, output bit did);
        inflight   = busy;
        resp_real  = 1'b0;
        data_valid = 1'b0;
        data       = $urandom;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                data_valid = 1'b1;
                data       = req_addr ^ 32'hA5A5_0000;
                busy       = 1'b0;
                resp_real  = 1'b1;
            end
        end else begin
            if (address_enable) begin
                busy     = 1'b1;
                cnt      = lat;
                req_addr = address;
            end
            // Stray response while idle must be ignored.
            if ($urandom_range(0, 5) == 0) data_valid = 1'b1;
        end
        did = (rmode == 1) || (rmode == 2 && resp_real) || (rmode == 3 && busy && !resp_real);
        hold           = h;
        redirect_valid = did;
        redirect_pc    = rpc;
    endtask

    task automatic step(input bit h, input int rmode, input logic [31:0] rpc, output bit did);
        @(negedge clock);
        model_and_check();
        mem_drive(h, rmode, rpc, did);
    endtask

    initial begin
        bit did;
        reset_n        = 1'b0;
        hold           = 1'b0;
        data           = '0;
        data_valid     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mpc = 32'h0; mflush = 1'b0;
        busy = 0; stale = 0; resp_real = 0; inflight = 0;
        lat = 1; m_stall = 0; m_flush = 0;
        repeat (3) @(negedge clock);
        check("reset_addr_en", address_enable, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_has_flushed", out_has_flushed, 1'b0);
        check("reset_next_pc", next_pc, 32'h4);
        reset_n = 1'b1;
        mem_drive(1'b0, 0, 32'h0, did);

        // Sequential fetch, single-cycle memory.
        repeat (20) step(1'b0, 0, 32'h0, did);
        // Decode stall fills the queue, then drains.
        repeat (10) step(1'b1, 0, 32'h0, did);
        check("hold_full_no_request", address_enable, 1'b0);
        repeat (10) step(1'b0, 0, 32'h0, did);

        // Redirect with a read in flight, slow memory.
        lat = 3;
        did = 0;
        for (int i = 0; i < 10 && !did; i++) step(1'b0, 3, 32'h100, did);
        check("redirect_inflight_seen", did, 1'b1);
        repeat (20) step(1'b0, 0, 32'h0, did);

        // Redirect coincident with a response and a pop.
        lat = 1;
        did = 0;
        for (int i = 0; i < 10 && !did; i++) step(1'b0, 2, 32'h200, did);
        check("redirect_coincident_seen", did, 1'b1);
        repeat (10) step(1'b0, 0, 32'h0, did);

        // Address wrap.
        step(1'b0, 1, 32'hFFFF_FFFC, did);
        repeat (15) step(1'b0, 0, 32'h0, did);

        // Perf-style phase: long latency, no hold.
        lat = 5;
        repeat (40) step(1'b0, 0, 32'h0, did);
        repeat (3) begin
            step(1'b0, 1, 32'h0000_0400, did);
            repeat (12) step(1'b0, 0, 32'h0, did);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if (i % 50 == 0) lat = $urandom_range(1, 5);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            step($urandom_range(0, 2) == 0, ($urandom_range(0, 39) == 0) ? 1 : 0, rpc, did);
        end

        // Let traffic settle with no redirect or hold pending.
        repeat (10) step(1'b0, 0, 32'h0, did);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
